// File: rtl/program_loader_pkg.sv
// Shared types and helpers for the program loader: FSM state encoding,
// word geometry and the byte-lane merge used by the assembler.
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RECV,
    WRITE,
    FINISH,
    RUN
  } state_t;

  localparam int WORD_BYTES = 4;

  // Return 'word' with byte lane 'lane' replaced by 'data' (little-endian lanes).
  function automatic logic [31:0] place_byte(input logic [31:0] word,
                                             input logic [7:0]  data,
                                             input logic [1:0]  lane);
    logic [31:0] merged;
    merged = word;
    merged[lane*8 +: 8] = data;
    return merged;
  endfunction

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
// The master side is the loader itself; the slave side is the stream
// source plus the instruction memory.
interface program_loader_if #(
  parameter int ADDR_WIDTH = 8
);
  logic [7:0]            rx_DATA;
  logic                  rx_VALID;
  logic                  rx_READY;
  logic                  im_WE;
  logic [ADDR_WIDTH-1:0] im_ADDR;
  logic [31:0]           im_DATA;

  modport master (
    input  rx_DATA, rx_VALID,
    output rx_READY, im_WE, im_ADDR, im_DATA
  );

  modport slave (
    output rx_DATA, rx_VALID,
    input  rx_READY, im_WE, im_ADDR, im_DATA
  );
endinterface

// File: rtl/program_loader_byte_assembler.sv
// Collects four bytes into one little-endian 32-bit word. 'word' is the
// word including the byte being pushed this cycle, so it is complete in
// the same cycle that 'word_ready' is high.
module byte_assembler
  import loader_pkg::*;
(
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        clear,
  input  logic        push,
  input  logic [7:0]  data_byte,
  output logic [31:0] word,
  output logic        word_ready
);

  logic [1:0]  byte_cnt;
  logic [31:0] lane_q;

  assign word       = place_byte(lane_q, data_byte, byte_cnt);
  assign word_ready = push && (byte_cnt == 2'(WORD_BYTES - 1));

  // Byte counter and lane register; a clear drops any partial word.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      byte_cnt <= '0;
      lane_q   <= '0;
    end else if (clear) begin
      byte_cnt <= '0;
      lane_q   <= '0;
    end else if (push) begin
      byte_cnt <= byte_cnt + 2'd1;
      lane_q   <= word;
    end
  end

endmodule

// File: rtl/program_loader.sv
// Program loader: receives a byte stream, writes assembled words to
// instruction memory sequentially and holds the processor in reset until
// the requested number of words has been loaded.
module program_loader
  import loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int MAX_WORDS  = 256
) (
  input  logic                CLK,
  input  logic                RESET_N,
  input  logic                START,
  input  logic [ADDR_WIDTH:0] LEN,
  program_loader_if.master    bus,
  output logic                cpu_RESET,
  output logic                BUSY,
  output logic                DONE,
  output logic                ERROR
);

  localparam logic [ADDR_WIDTH:0] MAX_LEN = (ADDR_WIDTH + 1)'(MAX_WORDS);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH:0]   len_q;
  logic [ADDR_WIDTH:0]   word_cnt;
  logic [ADDR_WIDTH-1:0] im_addr_q;
  logic [31:0]           im_data_q;
  logic                  error_q;

  logic        start_seen;
  logic        len_ok;
  logic        accept;
  logic        reject;
  logic        push;
  logic        last_word;
  logic [31:0] asm_word;
  logic        word_ready;

  assign start_seen = START && ((state_q == IDLE) || (state_q == RUN));
  assign len_ok     = (LEN != '0) && (LEN <= MAX_LEN);
  assign accept     = start_seen && len_ok;
  assign reject     = start_seen && !len_ok;
  assign push       = bus.rx_VALID && (state_q == RECV);
  assign last_word  = ((word_cnt + 1'b1) == len_q);

  byte_assembler u_asm (
    .CLK        (CLK),
    .RESET_N    (RESET_N),
    .clear      (accept),
    .push       (push),
    .data_byte  (bus.rx_DATA),
    .word       (asm_word),
    .word_ready (word_ready)
  );

  // State register.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic; illegal or mistimed starts leave the state alone.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, RUN: if (accept)     state_d = RECV;
      RECV:      if (word_ready) state_d = WRITE;
      WRITE:     state_d = last_word ? FINISH : RECV;
      FINISH:    state_d = RUN;
      default:   state_d = IDLE;
    endcase
  end

  // Length latch, word counter, write-port registers and sticky error.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      len_q     <= '0;
      word_cnt  <= '0;
      im_addr_q <= '0;
      im_data_q <= '0;
      error_q   <= 1'b0;
    end else begin
      if (accept) begin
        len_q    <= LEN;
        word_cnt <= '0;
        error_q  <= 1'b0;
      end else if (reject) begin
        error_q  <= 1'b1;
      end
      if (word_ready) begin
        im_data_q <= asm_word;
        im_addr_q <= word_cnt[ADDR_WIDTH-1:0];
      end
      if (state_q == WRITE) word_cnt <= word_cnt + 1'b1;
    end
  end

  assign bus.rx_READY = (state_q == RECV);
  assign bus.im_WE    = (state_q == WRITE);
  assign bus.im_ADDR  = im_addr_q;
  assign bus.im_DATA  = im_data_q;
  assign BUSY         = (state_q == RECV) || (state_q == WRITE);
  assign DONE         = (state_q == FINISH);
  assign cpu_RESET    = (state_q != RUN);
  assign ERROR        = error_q;

endmodule

// File: doc/program_loader.md
# program_loader

Hardware program loader that sits between a byte-stream source and the processor's instruction memory. It accepts bytes over a valid/ready handshake, assembles them into 32-bit little-endian words, and writes them sequentially into instruction memory through the `im_WE`/`im_DATA` write port. It holds the processor's pc/register-bank/flag resets asserted until the programmed length has been loaded, then releases them. It replaces the bench-driven file load for on-board bring-up.

## Interface
- `ADDR_WIDTH`, default 8: instruction-memory word-address width.
- `MAX_WORDS`, default 256: largest legal load length; must be ≤ 2^ADDR_WIDTH.
- `CLK`  in  1  system clock; all state changes on the rising edge.
- `RESET_N`  in  1  reset; asynchronous assertion, active-low.
- `START`  in  1  single-cycle request to begin a load.
- `LEN`  in  ADDR_WIDTH+1  word count; sampled only on an accepted `START`.
- `rx_DATA`  in  8  byte from the stream source.
- `rx_VALID`  in  1  `rx_DATA` is valid.
- `rx_READY`  out  1  loader accepts a byte this cycle.
- `im_WE`  out  1  instruction-memory write enable.
- `im_ADDR`  out  ADDR_WIDTH  instruction-memory word address.
- `im_DATA`  out  32  instruction-memory write data.
- `cpu_RESET`  out  1  active-high reset to the pc, register bank and flags.
- `BUSY`  out  1  load in progress.
- `DONE`  out  1  one-cycle pulse at load completion.
- `ERROR`  out  1  sticky flag for an illegal `LEN`.

## Operation
- States:
  - `IDLE`: `cpu_RESET=1`.
  - `RECV`: `rx_READY=1`, `BUSY=1`, `cpu_RESET=1`.
  - `WRITE`: `im_WE=1`, `BUSY=1`, `cpu_RESET=1`.
  - `FINISH`: `DONE=1`, `cpu_RESET=1`.
  - `RUN`: `cpu_RESET=0`.
- All outputs are decoded from the state register (Moore) or come from registers.
- Reset values: state `IDLE`; `cpu_RESET=1`; `rx_READY=0`, `im_WE=0`, `im_ADDR=0`, `im_DATA=0`, `BUSY=0`, `DONE=0`, `ERROR=0`; byte and word counters 0.
- An accepted `START` occurs in `IDLE` or `RUN` with `1 ≤ LEN ≤ MAX_WORDS`. It latches `LEN`, clears the counters, clears `ERROR`, and moves to `RECV`. From `RUN`, `cpu_RESET` reasserts on the next cycle.
- A `START` with `LEN=0` or `LEN>MAX_WORDS` sets `ERROR=1` and leaves the state unchanged.
- `START` in `RECV`, `WRITE` or `FINISH` is ignored.
- `RECV`:
  - A byte transfers on a rising edge where `rx_VALID && rx_READY`.
  - Byte k (k=0..3) lands in bits [8k+7:8k] of the assembly register.
  - After byte 3, move to `WRITE`.
- `WRITE`, for exactly one cycle:
  - `im_DATA` = assembled word, `im_ADDR` = word counter.
  - Then increment the word counter.
  - Go to `FINISH` if word counter+1 == latched `LEN`, else back to `RECV`.
- `FINISH` lasts one cycle, then goes to `RUN`.
- `im_DATA`/`im_ADDR` hold their last values outside `WRITE`.
- `RESET_N` low mid-load: immediate return to reset values. Words already written stay in memory; the partial word is discarded.

## Timing
- Byte to write: the 4th byte is accepted at edge N; `im_WE=1` during cycle N+1; `rx_READY=1` again from N+2.
- Peak throughput is one word per 5 cycles. `rx_READY` is low during `WRITE`.
- `rx_VALID` low stalls `RECV` indefinitely; there is no timeout.
- `DONE` is high during the cycle after the last `WRITE`. `cpu_RESET` falls at the following edge, so the processor's first fetch is at the cycle after that.
- `START` sampled at edge N: `BUSY=1` and `rx_READY=1` from cycle N+1.
- The address counter never wraps, because `LEN ≤ MAX_WORDS ≤ 2^ADDR_WIDTH`.

## Structure
- Package `loader_pkg` holds:
  - the state enum (`IDLE`, `RECV`, `WRITE`, `FINISH`, `RUN`);
  - `WORD_BYTES = 4`;
  - the byte-lane helper.
- Sub-module `byte_assembler`: 2-bit byte counter plus 32-bit shift/lane register. Inputs: `CLK`, `RESET_N`, `clear`, `push`, `byte`. Outputs: `word`, `word_ready`.
- The FSM, word counter and `LEN` latch live in `program_loader`.

## Test plan
- Reset release, no `START`: `cpu_RESET=1` and all other outputs 0 indefinitely.
- `START`, `LEN=2`, bytes 0x78,0x56,0x34,0x12,0xEF,0xBE,0xAD,0xDE with `rx_VALID` always high:
  - writes `im_ADDR=0`/0x12345678, then `im_ADDR=1`/0xDEADBEEF;
  - each `im_WE` pulse is one cycle wide;
  - `DONE` pulses once, then `cpu_RESET` falls.
- Same stream with `rx_VALID` toggled randomly: identical writes, and no byte is accepted while `rx_READY=0`.
- `START` with `LEN=0`, then `LEN=MAX_WORDS+1`: `ERROR=1`, state unchanged. A following `START` with `LEN=1` clears `ERROR` and loads normally.
- `START` asserted during `RECV`: ignored, and the load completes with the original `LEN`.
- `RESET_N` pulsed low after 6 bytes of `LEN=2`: word 0 stays written, `cpu_RESET=1`, counters 0, `DONE` never pulses.
